// File: rtl/tt_harness_pkg.sv
// tt_harness_pkg: shared FSM states, stimulus modes and default tap masks for the stimulus/signature harness
package tt_harness_pkg;
  typedef enum logic [1:0] {IDLE, RST_DUT, RUN, DONE} harness_state_t;
  localparam logic [1:0] MODE_CNT  = 2'd0;
  localparam logic [1:0] MODE_LFSR = 2'd1;
  localparam logic [1:0] MODE_WALK = 2'd2;
  localparam logic [1:0] MODE_HOLD = 2'd3;
  localparam logic [7:0] DEF_LFSR_TAPS = 8'hB8;
  localparam logic [31:0] DEF_MISR_TAPS = 32'h1021;
endpackage

// File: rtl/tt_misr.sv
// tt_misr: SIG_W-bit multiple-input signature register with clear, enable and XOR-folded input
module tt_misr #(
  parameter int SIG_W = 16,
  parameter int DW = 16,
  parameter logic [31:0] TAPS = 32'h1021
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [DW-1:0]    din,
  output logic [SIG_W-1:0] sig,
  output logic [SIG_W-1:0] sig_nxt
);
  logic [SIG_W-1:0] fold;
  always_comb begin
    fold = '0;
    for (int i = 0; i < DW; i++) fold[i % SIG_W] = fold[i % SIG_W] ^ din[i];
    sig_nxt = clr ? '0 : en ? {sig[SIG_W-2:0], ^(sig & TAPS[SIG_W-1:0])} ^ fold : sig;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) sig <= '0;
    else sig <= sig_nxt;
endmodule

// File: rtl/tt_stim_sig_harness.sv
// tt_stim_sig_harness: drives a TinyTapeout-style DUT from a pattern generator and checks its MISR signature
module tt_stim_sig_harness
  import tt_harness_pkg::*;
#(
  parameter int IN_W = 8,
  parameter int UIO_W = 8,
  parameter int OUT_W = 8,
  parameter int SIG_W = 16,
  parameter int NUM_CYCLES = 256,
  parameter int RST_CYCLES = 4,
  parameter int CAP_LAT = 1,
  parameter logic [7:0] LFSR_TAPS = DEF_LFSR_TAPS,
  parameter logic [31:0] MISR_TAPS = DEF_MISR_TAPS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [IN_W+UIO_W-1:0] seed,
  input  logic [SIG_W-1:0]      expected,
  output logic [IN_W-1:0]       dut_ui_in,
  output logic [UIO_W-1:0]      dut_uio_in,
  output logic                  dut_ena,
  output logic                  dut_rst_n,
  input  logic [OUT_W-1:0]      dut_uo_out,
  input  logic [UIO_W-1:0]      dut_uio_out,
  input  logic [UIO_W-1:0]      dut_uio_oe,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [SIG_W-1:0]      signature
);
  localparam int SW = IN_W + UIO_W;
  localparam int RUN_LEN = NUM_CYCLES + CAP_LAT;
  localparam int CW = $clog2((RST_CYCLES > RUN_LEN ? RST_CYCLES : RUN_LEN) + 1);
  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] RUN_LAST = CW'(RUN_LEN - 1);
  localparam logic [CW-1:0] STIM_LAST = CW'(NUM_CYCLES - 1);
  localparam logic [CW-1:0] CAP_FIRST = CW'(CAP_LAT);
  harness_state_t state;
  logic [1:0] mode_q;
  logic [SW-1:0] stim, stim_nxt, seed_ld;
  logic [CW-1:0] cnt;
  logic [SIG_W-1:0] sig_nxt;
  logic go, cap_en, last;
  assign go = start && (state == IDLE || state == DONE);
  assign cap_en = state == RUN && cnt >= CAP_FIRST;
  assign last = state == RUN && cnt == RUN_LAST;
  assign dut_ui_in = stim[IN_W-1:0];
  assign dut_uio_in = stim[IN_W +: UIO_W] & ~dut_uio_oe;
  // zero seeds would lock the LFSR and leave nothing to walk, so they load 1
  always_comb begin
    seed_ld = (seed == '0 && (mode == MODE_LFSR || mode == MODE_WALK)) ? SW'(1) : seed;
    stim_nxt = mode_q == MODE_CNT  ? stim + SW'(1) :
               mode_q == MODE_LFSR ? {stim[SW-2:0], ^(stim[7:0] & LFSR_TAPS)} :
               mode_q == MODE_WALK ? {stim[SW-2:0], stim[SW-1]} : stim;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      mode_q <= MODE_CNT;
      stim <= '0;
      cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      dut_ena <= 1'b0;
      dut_rst_n <= 1'b0;
    end else if (go) begin
      state <= RST_DUT;
      mode_q <= mode;
      stim <= seed_ld;
      cnt <= '0;
      busy <= 1'b1;
      done <= 1'b0;
      pass <= 1'b0;
      dut_ena <= 1'b1;
      dut_rst_n <= 1'b0;
    end else if (state == RST_DUT) begin
      cnt <= cnt == RST_LAST ? '0 : cnt + CW'(1);
      if (cnt == RST_LAST) begin
        state <= RUN;
        dut_rst_n <= 1'b1;
      end
    end else if (state == RUN) begin
      cnt <= cnt + CW'(1);
      if (cnt < STIM_LAST) stim <= stim_nxt;
      if (last) begin
        state <= DONE;
        busy <= 1'b0;
        done <= 1'b1;
        pass <= sig_nxt == expected;
      end
    end else if (state == DONE) begin
      pass <= sig_nxt == expected;
    end
  end
  tt_misr #(.SIG_W(SIG_W), .DW(OUT_W + UIO_W), .TAPS(MISR_TAPS)) u_misr (
    .clk(clk),
    .rst(rst),
    .en(cap_en),
    .clr(go),
    .din({dut_uo_out, dut_uio_out & dut_uio_oe}),
    .sig(signature),
    .sig_nxt(sig_nxt)
  );
endmodule

// File: tb/tb_tt_stim_sig_harness.sv
// tb_tt_stim_sig_harness: directed runs of every stimulus mode against a vector-list and signature model
module tb_tt_stim_sig_harness;
  import tt_harness_pkg::*;
  localparam int R = 4, N = 256, CAP = 1, L = N + CAP;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, echo = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [15:0] seed = 16'h0, expected = 16'h0;
  logic [7:0] ui_in, uio_in, uo, uio_o, oe = 8'h0;
  logic ena, rst_n, busy, done, pass;
  logic [15:0] signature;
  int n_pass = 0, n_total = 0, bc = 0;
  bit active = 1'b0;
  int t = 0;
  logic [15:0] m_sig = 16'h0, exp_q = 16'h0, cv;
  logic [15:0] vec_arr [N];

  always #5 clk = ~clk;

  tt_stim_sig_harness dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .seed(seed), .expected(expected),
    .dut_ui_in(ui_in), .dut_uio_in(uio_in), .dut_ena(ena), .dut_rst_n(rst_n),
    .dut_uo_out(uo), .dut_uio_out(uio_o), .dut_uio_oe(oe),
    .busy(busy), .done(done), .pass(pass), .signature(signature)
  );

  // DUT stub with one cycle of latency: echoes ui_in, and a scrambled copy onto uio_out
  always @(posedge clk) begin
    uo <= echo ? ui_in : 8'h0;
    uio_o <= echo ? ui_in ^ 8'h3C : 8'h0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ^(s[7:0] & 8'hB8)};
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [15:0] d);
    return {s[14:0], ^(s & 16'h1021)} ^ d;
  endfunction

  // list of the N vectors a run presents, and the signature the stub's responses must produce
  task automatic build(input logic [1:0] m, input logic [15:0] s);
    logic [15:0] v, lv, sg, d;
    v = (s == 16'h0 && (m == MODE_LFSR || m == MODE_WALK)) ? 16'h1 : s;
    lv = v;
    for (int k = 0; k < N; k++) begin
      vec_arr[k] = m == MODE_CNT ? v + 16'(k) :
                   m == MODE_LFSR ? lv :
                   m == MODE_WALK ? (v << (k % 16)) | (v >> (16 - k % 16)) : v;
      lv = lfsr_step(lv);
    end
    sg = 16'h0;
    for (int k = CAP; k < L; k++) begin
      d = echo ? {vec_arr[k-1][7:0], (vec_arr[k-1][7:0] ^ 8'h3C) & oe} : 16'h0;
      sg = misr_step(sg, d);
    end
    m_sig = sg;
  endtask

  // model phase: t counts cycles since the accepted start
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      active = 1'b0;
      t = 0;
    end else begin
      if (start && (!active || t >= R + L)) begin
        active = 1'b1;
        t = 0;
        build(mode, seed);
      end else if (active) t++;
      exp_q = expected;
    end
  end

  initial forever begin
    @(negedge clk);
    if (!active) begin
      chk("idle_busy", 32'(busy), 0);
      chk("idle_done", 32'(done), 0);
      chk("idle_pass", 32'(pass), 0);
      chk("idle_rst_n", 32'(rst_n), 0);
      chk("idle_ena", 32'(ena), 0);
      chk("idle_ui", 32'(ui_in), 0);
      chk("idle_uio", 32'(uio_in), 0);
      chk("idle_sig", 32'(signature), 0);
    end else begin
      cv = vec_arr[t < R ? 0 : (t - R > N - 1 ? N - 1 : t - R)];
      chk("busy", 32'(busy), 32'(t < R + L));
      chk("done", 32'(done), 32'(t >= R + L));
      chk("rst_n", 32'(rst_n), 32'(t >= R));
      chk("ena", 32'(ena), 1);
      chk("ui_in", 32'(ui_in), 32'(cv[7:0]));
      chk("uio_in", 32'(uio_in), 32'(cv[15:8] & ~oe));
      chk("pass", 32'(pass), 32'(t >= R + L && m_sig == exp_q));
      if (t < R) chk("sig_clear", 32'(signature), 0);
      if (t >= R + L) chk("sig_final", 32'(signature), 32'(m_sig));
    end
  end

  task automatic tick();
    if (busy) bc++;
    @(negedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic go(input logic [1:0] m, input logic [15:0] s);
    mode = m;
    seed = s;
    start = 1'b1;
    tick();
    start = 1'b0;
    mode = ~m;
    seed = ~s;
    bc = 0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 1000) begin
      tick();
      n++;
    end
    chk("done_reached", 32'(done), 1);
  endtask

  initial begin
    logic zs;
    ticks(3);
    rst = 1'b0;
    ticks(2);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_sig", 32'(signature), 0);
    // counter, zero stub
    go(MODE_CNT, 16'h0010);
    ticks(R);
    chk("cnt_ui0", 32'(ui_in), 32'h10);
    chk("cnt_uio0", 32'(uio_in), 32'h00);
    tick();
    chk("cnt_ui1", 32'(ui_in), 32'h11);
    tick();
    chk("cnt_ui2", 32'(ui_in), 32'h12);
    wait_done();
    chk("cnt_busy_len", 32'(bc), 32'd261);
    chk("cnt_sig", 32'(signature), 0);
    chk("cnt_pass", 32'(pass), 1);
    expected = 16'h0001;
    tick();
    chk("cnt_pass_exp1", 32'(pass), 0);
    // walking one with the upper uio nibble driven by the DUT
    expected = 16'h0;
    oe = 8'hF0;
    go(MODE_WALK, 16'h0);
    ticks(R);
    for (int k = 0; k <= 16; k++) begin
      if (k == 0) chk("walk_ui0", 32'(ui_in), 32'h01);
      if (k == 0) chk("walk_uio0", 32'(uio_in), 32'h00);
      if (k == 7) chk("walk_ui7", 32'(ui_in), 32'h80);
      if (k == 8) chk("walk_ui8", 32'(ui_in), 32'h00);
      if (k == 8) chk("walk_uio8", 32'(uio_in), 32'h01);
      if (k == 12) chk("walk_uio12_masked", 32'(uio_in), 32'h00);
      if (k == 16) chk("walk_ui16", 32'(ui_in), 32'h01);
      tick();
    end
    wait_done();
    // LFSR with echo stub, golden signature from the model
    oe = 8'h00;
    echo = 1'b1;
    go(MODE_LFSR, 16'h0);
    expected = m_sig;
    ticks(R);
    zs = 1'b0;
    for (int k = 0; k < N; k++) begin
      if ({uio_in, ui_in} == 16'h0) zs = 1'b1;
      if (k == 0) chk("lfsr_ui0", 32'(ui_in), 32'h01);
      if (k == 0) chk("lfsr_uio0", 32'(uio_in), 32'h00);
      if (k == 1) chk("lfsr_ui1", 32'(ui_in), 32'h02);
      if (k == 4) chk("lfsr_ui4", 32'(ui_in), 32'h11);
      tick();
    end
    chk("lfsr_nonzero", 32'(zs), 0);
    wait_done();
    chk("lfsr_pass", 32'(pass), 1);
    // hold mode, with a start pulse mid-run that must be ignored
    expected = 16'h0;
    oe = 8'h3C;
    go(MODE_HOLD, 16'hA55A);
    ticks(R);
    chk("hold_ui0", 32'(ui_in), 32'h5A);
    chk("hold_uio0", 32'(uio_in), 32'h81);
    ticks(5);
    chk("hold_ui5", 32'(ui_in), 32'h5A);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done();
    chk("hold_busy_len", 32'(bc), 32'd261);
    // restart from DONE, then reset at RUN cycle 10
    oe = 8'h00;
    go(MODE_CNT, 16'h0001);
    chk("restart_done", 32'(done), 0);
    chk("restart_busy", 32'(busy), 1);
    chk("restart_sig", 32'(signature), 0);
    chk("restart_rst_n", 32'(rst_n), 0);
    ticks(R + 10);
    rst = 1'b1;
    tick();
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_rst_n", 32'(rst_n), 0);
    chk("midrst_sig", 32'(signature), 0);
    rst = 1'b0;
    ticks(3);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
